seq_pattern_gen: RTL and testbench

//  Bit-serial pattern transmitter; the stimulus source for the serial sequence detectors in ACA.

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_gen_lfsr.sv | 33 +++
 rtl/seq_pattern_gen.sv | 181 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Default pattern sent when the caller asks for the built-in one.
    localparam logic [3:0] PAT_DEF_C = 4'b1001;

    // PRBS-7 (x^7 + x^6 + 1): seed loaded on reset and feedback tap mask.
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [6:0] PRBS_TAPS = 7'b110_0000;

endpackage

// File: rtl/seq_gen_lfsr.sv
// PRBS-7 generator used to fill idle cycles with pseudo-random traffic.
// Only instantiated when SEQ_GEN_PRBS_FILL_EN is defined.
module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic bit_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    logic       feedback;

    // Feedback is the XOR of the tapped stages; shift toward the MSB.
    always_comb begin
        feedback = ^(lfsr_q & PRBS_TAPS);
        lfsr_d   = enable_i ? {lfsr_q[5:0], feedback} : lfsr_q;
    end

    // Shift register state, reseeded asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[6];

endmodule

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: latches a pattern on start, sends it
// MSB-first a programmed number of times with an idle gap between copies,
// then pulses done. Optional PRBS idle fill enabled by SEQ_GEN_PRBS_FILL_EN.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_DEF_C),
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             use_def_i,
    input  logic [PAT_W-1:0] pattern_in_i,
    input  logic [CNT_W-1:0] repeat_cnt_i,
    input  logic [GAP_W-1:0] gap_len_i,
    output logic             serial_bit_o,
    output logic             bit_valid_o,
    output logic             frame_start_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             BW       = $clog2(PAT_W);
    localparam logic [BW-1:0]  BIT_LAST = BW'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic             serial_q, serial_d;
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fillBit;

`ifdef SEQ_GEN_PRBS_FILL_EN
    seq_gen_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .enable_i (1'b1),
        .bit_o    (fillBit)
    );
`else
    assign fillBit = 1'b0;
`endif

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        gapCnt_d = gapCnt_q;
        serial_d = 1'b0;
        valid_d  = 1'b0;
        frame_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (repeat_cnt_i != '0) begin
                            pat_d    = use_def_i ? PAT_DEF : pattern_in_i;
                            shift_d  = pat_d;
                            bitCnt_d = '0;
                            rem_d    = repeat_cnt_i;
                            gap_d    = gap_len_i;
                            state_d  = SEND;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SEND: begin
                    if (bitCnt_q == BIT_LAST) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end else if (gap_q == '0) begin
                            shift_d  = pat_q;
                            bitCnt_d = '0;
                        end else begin
                            gapCnt_d = gap_q;
                            state_d  = GAP;
                        end
                    end else begin
                        shift_d  = shift_q << 1;
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt_q == GAP_W'(1)) begin
                        shift_d  = pat_q;
                        bitCnt_d = '0;
                        state_d  = SEND;
                    end else begin
                        gapCnt_d = gapCnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        case (state_d)
            SEND: begin
                serial_d = shift_d[PAT_W-1];
                valid_d  = 1'b1;
                frame_d  = (bitCnt_d == '0);
                busy_d   = 1'b1;
            end
            GAP: begin
                serial_d = fillBit;
                busy_d   = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                serial_d = fillBit & ~abort_i;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            shift_q  <= '0;
            bitCnt_q <= '0;
            rem_q    <= '0;
            gap_q    <= '0;
            gapCnt_q <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            gapCnt_q <= gapCnt_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial_bit_o  = serial_q;
    assign bit_valid_o   = valid_q;
    assign frame_start_o = frame_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes hand-computed
// per-cycle output vectors {serial,valid,frame,busy,done}; a monitor pops
// and compares them on the falling edge.
module tb_seq_pattern_gen;

    typedef struct {
        int unsigned cycle;
        logic [4:0]  vec;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       useDef;
    logic [3:0] patternIn;
    logic [7:0] repeatCnt;
    logic [3:0] gapLen;
    logic       serialBit;
    logic       bitValid;
    logic       frameStart;
    logic       busy;
    logic       done;

    exp_t        expQ[$];
    exp_t        monEntry;
    int unsigned cycle;
    int          compared;
    int          mismatched;

    seq_pattern_gen dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .abort_i       (abort),
        .use_def_i     (useDef),
        .pattern_in_i  (patternIn),
        .repeat_cnt_i  (repeatCnt),
        .gap_len_i     (gapLen),
        .serial_bit_o  (serialBit),
        .bit_valid_o   (bitValid),
        .frame_start_o (frameStart),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to align expectations with DUT outputs.
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Compare one popped expectation against the live outputs.
    task automatic checkOutput(input exp_t e);
        logic [4:0] actual;
        actual = {serialBit, bitValid, frameStart, busy, done};
        compared++;
        if (actual !== e.vec || e.cycle != cycle) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d (due %0d): got {ser,val,frm,bsy,dn}=%b expected %b",
                     e.name, cycle, e.cycle, actual, e.vec);
        end
    endtask

    // Monitor: pop every expectation that is due this cycle.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cycle <= cycle) begin
            monEntry = expQ.pop_front();
            checkOutput(monEntry);
        end
    end

    task automatic pushExp(input int unsigned c, input logic [4:0] v, input string nm);
        exp_t e;
        e.cycle = c;
        e.vec   = v;
        e.name  = nm;
        expQ.push_back(e);
    endtask

    // Drive a burst request then n cycles; bit i of each vector (MSB-first) is cycle i+1 after start.
    task automatic applyStimulus(input string nm, input logic ud, input logic [3:0] pat,
                                 input logic [7:0] rep, input logic [3:0] gap, input int n,
                                 input int startAgainAt, input int abortAt,
                                 input logic [63:0] sBits, input logic [63:0] vBits,
                                 input logic [63:0] fBits, input logic [63:0] bBits,
                                 input logic [63:0] dBits);
        for (int i = 0; i < n; i++) begin
            start     = (i == 0) || (i == startAgainAt);
            abort     = (i == abortAt);
            useDef    = ud;
            patternIn = pat;
            repeatCnt = rep;
            gapLen    = gap;
            pushExp(cycle + 1, {sBits[n-1-i], vBits[n-1-i], fBits[n-1-i],
                                bBits[n-1-i], dBits[n-1-i]}, nm);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idleCycles(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            pushExp(cycle + 1, 5'b00000, nm);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        useDef     = 1'b0;
        patternIn  = '0;
        repeatCnt  = '0;
        gapLen     = '0;

        repeat (2) @(posedge clk);
        #1;
        pushExp(cycle, 5'b00000, "resetState");
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idleCycles("idleAfterReset", 2);

        applyStimulus("defSingle", 1'b1, 4'b0000, 8'd1, 4'd0, 6, -1, -1,
                      64'b100100, 64'b111100, 64'b100000, 64'b111110, 64'b000010);

        applyStimulus("userRep3Gap2", 1'b0, 4'b1101, 8'd3, 4'd2, 18, -1, -1,
                      64'b110100110100110100, 64'b111100111100111100,
                      64'b100000100000100000, 64'b111111111111111110,
                      64'b000000000000000010);

        applyStimulus("backToBack", 1'b1, 4'b0000, 8'd2, 4'd0, 10, 3, -1,
                      64'b1001100100, 64'b1111111100, 64'b1000100000,
                      64'b1111111110, 64'b0000000010);

        applyStimulus("zeroRepeat", 1'b0, 4'b1111, 8'd0, 4'd3, 3, -1, -1,
                      64'b000, 64'b000, 64'b000, 64'b100, 64'b100);

        applyStimulus("abortSecondBit", 1'b0, 4'b1011, 8'd4, 4'd1, 6, -1, 2,
                      64'b100000, 64'b110000, 64'b100000, 64'b110000, 64'b000000);

        applyStimulus("startAfterAbort", 1'b0, 4'b0110, 8'd1, 4'd3, 6, -1, -1,
                      64'b011000, 64'b111100, 64'b100000, 64'b111110, 64'b000010);

        applyStimulus("abortWinsStart", 1'b1, 4'b0000, 8'd2, 4'd0, 3, -1, 0,
                      64'b000, 64'b000, 64'b000, 64'b000, 64'b000);

        applyStimulus("maxGap", 1'b1, 4'b0000, 8'd2, 4'd15, 25, -1, -1,
                      {39'b0, 4'b1001, 15'b0, 4'b1001, 2'b00},
                      {39'b0, 4'b1111, 15'b0, 4'b1111, 2'b00},
                      {39'b0, 4'b1000, 15'b0, 4'b1000, 2'b00},
                      {39'b0, 24'hFFFFFF, 1'b0},
                      {39'b0, 23'b0, 2'b10});

        applyStimulus("preResetBurst", 1'b0, 4'b1101, 8'd2, 4'd3, 5, -1, -1,
                      64'b11010, 64'b11110, 64'b10000, 64'b11111, 64'b00000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pushExp(cycle, 5'b00000, "asyncResetMidGap");
        @(posedge clk);
        #1;
        pushExp(cycle, 5'b00000, "holdReset");
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idleCycles("idleAfterMidReset", 2);

        applyStimulus("recoverAfterReset", 1'b1, 4'b0000, 8'd1, 4'd0, 6, -1, -1,
                      64'b100100, 64'b111100, 64'b100000, 64'b111110, 64'b000010);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
